// File: rtl/pcie_bar_avmm_slave.sv
// BAR0 register/scratch-RAM responder for the PCIe HIP Rxm Avalon-MM master; bursts up to 15 beats.
// Reads: first beat 2 cycles after accept, then 1 beat/cycle. Stalls via waitrequest during read bursts only.
// Optional PCIE_BAR_IRQ_EN adds irq_out, driven from a doorbell-pending flag.
module pcie_bar_avmm_slave #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter int                BURST_W   = 4,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 8'h40,
    parameter int                MEM_WORDS = 64,
    parameter logic [DATA_W-1:0] ID_VALUE  = 32'hC5A0_0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    input  logic [BURST_W-1:0]    avs_burstcount,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    output logic                  doorbell_pulse
`ifdef PCIE_BAR_IRQ_EN
    ,
    output logic                  irq_out
`endif
);

    localparam int BE_W   = DATA_W / 8;
    localparam int MEM_AW = $clog2(MEM_WORDS);

    localparam logic [ADDR_W-1:0] A_ID       = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_SCRATCH  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CONTROL  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_DOORBELL = ADDR_W'(3);
    localparam logic [ADDR_W:0]   MEM_LO     = {1'b0, MEM_BASE};
    localparam logic [ADDR_W:0]   MEM_HI     = {1'b0, MEM_BASE} + (ADDR_W+1)'(MEM_WORDS);
    localparam logic [DATA_W-1:0] UNMAPPED   = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t               state;
    logic [ADDR_W-1:0]    burst_addr;
    logic [BURST_W-1:0]   remaining;
    logic [DATA_W-1:0]    scratch;
    logic                 ctrl_en;
    logic [31:0]          doorbell_cnt;
    logic [DATA_W-1:0]    ctrl_rd;
    logic [DATA_W-1:0]    mem [MEM_WORDS];

    logic                 wr_fire;
    logic [ADDR_W-1:0]    wr_addr;
    logic [BURST_W-1:0]   beats;

    assign beats   = (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;
    assign wr_fire = avs_write && ((state == IDLE) || (state == WR_BURST));
    assign wr_addr = (state == IDLE) ? avs_address : burst_addr;

    function automatic logic in_mem(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= MEM_LO) && ({1'b0, a} < MEM_HI);
    endfunction

    function automatic logic [MEM_AW-1:0] mem_idx(input logic [ADDR_W-1:0] a);
        return MEM_AW'(a - MEM_BASE);
    endfunction

    function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_d,
                                                   input logic [DATA_W-1:0] new_d,
                                                   input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_d;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r[8*i +: 8] = new_d[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        case (a)
            A_ID:       r = ID_VALUE;
            A_SCRATCH:  r = scratch;
            A_CONTROL:  r = ctrl_rd;
            A_DOORBELL: r = DATA_W'(doorbell_cnt);
            default:    r = in_mem(a) ? mem[mem_idx(a)] : UNMAPPED;
        endcase
        return r;
    endfunction

`ifdef PCIE_BAR_IRQ_EN
    logic irq_pending;
    logic irq_clr;

    assign irq_clr = wr_fire && (wr_addr == A_CONTROL) && avs_byteenable[0] && avs_writedata[1];
    assign ctrl_rd = {{(DATA_W-3){1'b0}}, irq_pending, 1'b0, ctrl_en};
    assign irq_out = ctrl_en & irq_pending;

    // A doorbell pulse arriving with a clear keeps the interrupt pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_pending <= 1'b0;
        end else if (doorbell_pulse) begin
            irq_pending <= 1'b1;
        end else if (irq_clr) begin
            irq_pending <= 1'b0;
        end
    end
`else
    assign ctrl_rd = {{(DATA_W-1){1'b0}}, ctrl_en};
`endif

    always_ff @(posedge clk) begin
        if (wr_fire && !reset && in_mem(wr_addr)) begin
            for (int i = 0; i < BE_W; i++) begin
                if (avs_byteenable[i]) mem[mem_idx(wr_addr)][8*i +: 8] <= avs_writedata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            burst_addr        <= '0;
            remaining         <= '0;
            scratch           <= '0;
            ctrl_en           <= 1'b0;
            doorbell_cnt      <= '0;
            avs_waitrequest   <= 1'b0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            doorbell_pulse    <= 1'b0;
        end else begin
            avs_readdatavalid <= 1'b0;
            doorbell_pulse    <= 1'b0;

            if (wr_fire) begin
                case (wr_addr)
                    A_SCRATCH: scratch <= merge_be(scratch, avs_writedata, avs_byteenable);
                    A_CONTROL: if (avs_byteenable[0]) ctrl_en <= avs_writedata[0];
                    A_DOORBELL: begin
                        if (|avs_byteenable) begin
                            doorbell_cnt   <= doorbell_cnt + 32'd1;
                            doorbell_pulse <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    // Write wins over a simultaneous read; the read is dropped.
                    if (avs_write) begin
                        if (beats > BURST_W'(1)) begin
                            burst_addr <= avs_address + 1'b1;
                            remaining  <= beats - 1'b1;
                            state      <= WR_BURST;
                        end
                    end else if (avs_read) begin
                        burst_addr      <= avs_address;
                        remaining       <= beats;
                        avs_waitrequest <= 1'b1;
                        state           <= RD_BURST;
                    end
                end
                WR_BURST: begin
                    if (avs_write) begin
                        burst_addr <= burst_addr + 1'b1;
                        remaining  <= remaining - 1'b1;
                        if (remaining == BURST_W'(1)) state <= IDLE;
                    end
                end
                RD_BURST: begin
                    avs_readdata      <= read_word(burst_addr);
                    avs_readdatavalid <= 1'b1;
                    burst_addr        <= burst_addr + 1'b1;
                    remaining         <= remaining - 1'b1;
                    if (remaining == BURST_W'(1)) begin
                        avs_waitrequest <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_no_read_with_write: assert property (@(posedge clk) disable iff (reset)
        (state == IDLE) |-> !(avs_read && avs_write));

endmodule

// File: tb/tb_pcie_bar_avmm_slave.sv
// Randomized self-checking bench for pcie_bar_avmm_slave against a register-map reference model.
module tb_pcie_bar_avmm_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [3:0]  avs_burstcount;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        doorbell_pulse;
`ifdef PCIE_BAR_IRQ_EN
    logic        irq_out;
`endif

    always #5 clk = ~clk;

    pcie_bar_avmm_slave dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_burstcount    (avs_burstcount),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .doorbell_pulse    (doorbell_pulse)
`ifdef PCIE_BAR_IRQ_EN
        ,
        .irq_out           (irq_out)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (doorbell_pulse === 1'b1) pulse_seen <= pulse_seen + 1;

    // Reference model of the BAR0 map
    logic [31:0] m_mem [256];
    bit          m_known [256];
    logic [31:0] m_scratch;
    logic [31:0] m_cnt;
    bit          m_ctrl_en;
    bit          m_pending;
    int          m_last_db;

    logic [31:0] wd  [16];
    logic [3:0]  wbe [16];

    function automatic logic [31:0] apply_be(input logic [31:0] old_d, input logic [31:0] d,
                                             input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
        return (old_d & ~m) | (d & m);
    endfunction

    task automatic model_reset();
        m_scratch = 32'h0;
        m_cnt     = 32'h0;
        m_ctrl_en = 1'b0;
        m_pending = 1'b0;
        m_last_db = -10;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                               input int c);
        if (a == 8'h01) begin
            m_scratch = apply_be(m_scratch, d, be);
        end else if (a == 8'h02) begin
            if (be[0]) begin
                m_ctrl_en = d[0];
                if (d[1] && m_last_db != c - 1) m_pending = 1'b0;
            end
        end else if (a == 8'h03) begin
            if (be != 4'h0) begin
                m_cnt     = m_cnt + 1;
                m_pending = 1'b1;
                m_last_db = c;
            end
        end else if (a >= 8'h40 && a <= 8'h7F) begin
            m_mem[a]   = apply_be(m_known[a] ? m_mem[a] : 32'h0, d, be);
            m_known[a] = (be == 4'hF) || m_known[a];
        end
    endtask

    function automatic bit model_read(input logic [7:0] a, output logic [31:0] d);
        d = 32'hDEAD_BEEF;
        if (a == 8'h00) d = 32'hC5A0_0001;
        else if (a == 8'h01) d = m_scratch;
        else if (a == 8'h02) begin
`ifdef PCIE_BAR_IRQ_EN
            d = {29'h0, m_pending, 1'b0, m_ctrl_en};
`else
            d = {31'h0, m_ctrl_en};
`endif
        end
        else if (a == 8'h03) d = m_cnt;
        else if (a >= 8'h40 && a <= 8'h7F) begin
            d = m_mem[a];
            return m_known[a];
        end
        return 1'b1;
    endfunction

    // Entered and left just after a falling edge; beats come from wd/wbe.
    task automatic do_write(input logic [7:0] a, input logic [3:0] bc, input int gap_after);
        int n;
        n = (bc == 4'h0) ? 1 : int'(bc);
        for (int i = 0; i < n; i++) begin
            avs_write      = 1'b1;
            avs_address    = (i == 0) ? a : 8'($urandom);
            avs_burstcount = (i == 0) ? bc : 4'($urandom);
            avs_writedata  = wd[i];
            avs_byteenable = wbe[i];
            checks++;
            if (avs_waitrequest !== 1'b0) begin
                errors++;
                $display("FAIL wr_waitrequest addr %0h beat %0d got %b exp 0", a, i, avs_waitrequest);
            end
            model_write(a + 8'(i), wd[i], wbe[i], cyc);
            @(negedge clk);
            if (i == gap_after && i != n - 1) begin
                avs_write = 1'b0;
                @(negedge clk);
            end
        end
        avs_write = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] bc);
        int n, got, first, wr_cyc;
        bit order_ok;
        logic [31:0] exp_d [16];
        bit          exp_k [16];
        n = (bc == 4'h0) ? 1 : int'(bc);
        for (int i = 0; i < n; i++) exp_k[i] = model_read(a + 8'(i), exp_d[i]);
        checks++;
        if (avs_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL rd_idle_waitrequest addr %0h got %b exp 0", a, avs_waitrequest);
        end
        avs_read       = 1'b1;
        avs_address    = a;
        avs_burstcount = bc;
        @(negedge clk);
        avs_read = 1'b0;
        got = 0; first = -1; wr_cyc = 0; order_ok = 1'b1;
        for (int k = 1; k <= n + 3; k++) begin
            if (avs_waitrequest === 1'b1) wr_cyc++;
            if (avs_readdatavalid === 1'b1) begin
                if (first < 0) first = k;
                if (k != first + got) order_ok = 1'b0;
                if (got < n && exp_k[got]) begin
                    checks++;
                    if (avs_readdata !== exp_d[got]) begin
                        errors++;
                        $display("FAIL rd_data addr %0h beat %0d got %h exp %h", a + 8'(got), got,
                                 avs_readdata, exp_d[got]);
                    end
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (first != 2) begin
            errors++;
            $display("FAIL rd_latency addr %0h got %0d exp 2", a, first);
        end
        checks++;
        if (got != n || !order_ok) begin
            errors++;
            $display("FAIL rd_beats addr %0h got %0d contiguous %0d exp %0d contiguous 1", a, got, order_ok, n);
        end
        checks++;
        if (wr_cyc != n) begin
            errors++;
            $display("FAIL rd_waitrequest_cycles addr %0h got %0d exp %0d", a, wr_cyc, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        avs_read = 1'b0; avs_write = 1'b0; avs_address = 8'h0;
        avs_writedata = 32'h0; avs_byteenable = 4'h0; avs_burstcount = 4'h1;
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({avs_waitrequest, avs_readdatavalid, doorbell_pulse} !== 3'b000 || avs_readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got wr=%b rdv=%b pulse=%b rd=%h exp 0 0 0 0", avs_waitrequest,
                     avs_readdatavalid, doorbell_pulse, avs_readdata);
        end
        reset = 1'b0;
        model_reset();
        do_read(8'h00, 4'd1);
        do_read(8'h01, 4'd3);
    endtask

    task automatic test_scratch_be();
        wd[0] = 32'h1234_5678; wbe[0] = 4'b0101;
        do_write(8'h01, 4'd1, -1);
        do_read(8'h01, 4'd1);
        do_read(8'h10, 4'd1);
    endtask

    task automatic test_burst_cross();
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'(i + 1); wbe[i] = 4'hF;
        end
        do_write(8'h7E, 4'd4, 1);
        do_read(8'h7E, 4'd4);
    endtask

    task automatic test_doorbell();
        int base;
        base = pulse_seen;
        for (int i = 0; i < 4; i++) begin
            wd[0]  = $urandom;
            wbe[0] = (i == 2) ? 4'h0 : 4'($urandom_range(1, 15));
            do_write(8'h03, 4'd1, -1);
        end
        @(negedge clk);
        checks++;
        if (pulse_seen - base != 3) begin
            errors++;
            $display("FAIL doorbell_pulses got %0d exp 3", pulse_seen - base);
        end
        do_read(8'h03, 4'd1);
        force dut.doorbell_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.doorbell_cnt;
        m_cnt = 32'hFFFF_FFFF;
        do_read(8'h03, 4'd1);
        wd[0] = $urandom; wbe[0] = 4'h8;
        do_write(8'h03, 4'd0, -1);
        do_read(8'h03, 4'd1);
    endtask

    task automatic test_reset_mid_burst();
        int beats_seen;
        bit reached;
        wd[0] = 32'hA5A5_5A5A; wbe[0] = 4'hF;
        do_write(8'h45, 4'd1, -1);
        wd[0] = 32'h1111_2222;
        do_write(8'h01, 4'd1, -1);
        avs_read = 1'b1; avs_address = 8'h40; avs_burstcount = 4'd15;
        @(negedge clk);
        avs_read = 1'b0;
        beats_seen = 0; reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            if (avs_readdatavalid === 1'b1) beats_seen++;
            if (beats_seen == 5) reached = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL midburst_reach got %0d beats exp 5", beats_seen);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({avs_waitrequest, avs_readdatavalid, doorbell_pulse} !== 3'b000 || avs_readdata !== 32'h0) begin
            errors++;
            $display("FAIL midburst_reset got wr=%b rdv=%b pulse=%b rd=%h exp 0 0 0 0", avs_waitrequest,
                     avs_readdatavalid, doorbell_pulse, avs_readdata);
        end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (avs_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL midburst_discard got rdv=%b exp 0", avs_readdatavalid);
        end
        do_read(8'h01, 4'd1);
        do_read(8'h45, 4'd1);
    endtask

`ifdef PCIE_BAR_IRQ_EN
    task automatic test_irq();
        wbe[0] = 4'hF;
        wd[0] = 32'h3;
        do_write(8'h02, 4'd1, -1);
        @(negedge clk);
        wd[0] = $urandom;
        do_write(8'h03, 4'd1, -1);
        checks++;
        if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq_out); end
        @(negedge clk);
        checks++;
        if (irq_out !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq_out); end
        wd[0] = 32'h3;
        do_write(8'h02, 4'd1, -1);
        checks++;
        if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq_out); end
        wd[0] = $urandom;
        do_write(8'h03, 4'd1, -1);
        @(negedge clk);
        wd[0] = 32'h0;
        do_write(8'h02, 4'd1, -1);
        checks++;
        if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", irq_out); end
        do_read(8'h02, 4'd1);
    endtask
`endif

    task automatic test_random();
        logic [7:0] a;
        int n;
        for (int op = 0; op < 40; op++) begin
            case ($urandom_range(0, 3))
                0: a = 8'($urandom_range(0, 5));
                1: a = 8'($urandom_range(8'h38, 8'h7F));
                2: a = 8'($urandom_range(0, 255));
                default: a = 8'($urandom_range(8'h40, 8'h7F));
            endcase
            if ($urandom_range(0, 1) == 0) begin
                n = $urandom_range(0, 8);
                for (int i = 0; i < 16; i++) begin
                    wd[i]  = $urandom;
                    wbe[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                end
                do_write(a, 4'(n), $urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : -1);
            end else begin
                do_read(a, 4'($urandom_range(0, 15)));
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scratch_be();
        test_burst_cross();
        test_doorbell();
        test_reset_mid_burst();
`ifdef PCIE_BAR_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
